// File: rtl/sha256core_in_arb.sv
// Two-requester round-robin arbiter that moves one 16-word block at a time
// from a show-ahead FIFO into the SHA-256 core input buffer.
module sha256core_in_arb #(
    parameter int BLK_OP_W = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                req0,
    input  logic                req1,
    input  logic [31:0]         din0,
    input  logic [31:0]         din1,
    input  logic [BLK_OP_W-1:0] blk_op0,
    input  logic [BLK_OP_W-1:0] blk_op1,
    output logic                rd0,
    output logic                rd1,
    input  logic                core_ready,
    output logic                wr_en,
    output logic [3:0]          wr_addr,
    output logic [31:0]         dout,
    output logic [BLK_OP_W-1:0] blk_op,
    output logic                input_seq,
    output logic                set_input_ready,
    output logic                idle
);

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

    state_t     state, state_nxt;
    logic [3:0] word_cnt;
    logic       hold_cnt;
    logic       last_grant;
    logic       grant_sel;
    logic       start;

    // Round-robin only matters under contention; a lone request always wins.
    always_comb begin
        grant_sel = (req0 && req1) ? ~last_grant : req1;
        start     = (state == IDLE) && core_ready && (req0 || req1);
    end

    always_comb begin
        state_nxt = state;
        rd0       = 1'b0;
        rd1       = 1'b0;
        idle      = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (start)
                    state_nxt = XFER;
            end
            XFER: begin
                rd0 = ~input_seq;
                rd1 = input_seq;
                if (word_cnt == 4'd15)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_cnt)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            word_cnt   <= 4'd0;
            hold_cnt   <= 1'b0;
            last_grant <= 1'b1;
            blk_op     <= '0;
            input_seq  <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_cnt <= (state == XFER) ? word_cnt + 4'd1 : 4'd0;
            hold_cnt <= (state == HOLD);
            if (start) begin
                last_grant <= grant_sel;
                input_seq  <= grant_sel;
                blk_op     <= grant_sel ? blk_op1 : blk_op0;
            end
        end
    end

    // The popped word and its address land on the core one cycle after the pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_en           <= 1'b0;
            wr_addr         <= 4'd0;
            dout            <= 32'd0;
            set_input_ready <= 1'b0;
        end else begin
            wr_en           <= (state == XFER);
            set_input_ready <= (state == XFER) && (word_cnt == 4'd15);
            if (state == XFER) begin
                wr_addr <= word_cnt;
                dout    <= input_seq ? din1 : din0;
            end
        end
    end

endmodule

// File: tb/tb_sha256core_in_arb.sv
// Directed bench for sha256core_in_arb: FIFO models feed the arbiter and each
// written block is compared word by word against the expected FIFO contents.
module tb_sha256core_in_arb;

    logic        CLK;
    logic        RST_N;
    logic        req0, req1;
    logic [31:0] din0, din1;
    logic [7:0]  blk_op0, blk_op1;
    logic        rd0, rd1;
    logic        core_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] dout;
    logic [7:0]  blk_op;
    logic        input_seq;
    logic        set_input_ready;
    logic        idle;

    sha256core_in_arb #(.BLK_OP_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0), .req1(req1),
        .din0(din0), .din1(din1),
        .blk_op0(blk_op0), .blk_op1(blk_op1),
        .rd0(rd0), .rd1(rd1),
        .core_ready(core_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .dout(dout),
        .blk_op(blk_op), .input_seq(input_seq),
        .set_input_ready(set_input_ready), .idle(idle)
    );

    typedef struct {
        logic [31:0] din;
        logic [3:0]  addr;
        logic        last;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] fifo0[64];
    logic [31:0] fifo1[64];
    logic [5:0]  ptr0, ptr1;
    int          cyc;
    int          tests, failed;
    int          nblk0, nblk1;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Show-ahead FIFO models: head word visible, advanced on each pop.
    assign din0 = fifo0[ptr0];
    assign din1 = fifo1[ptr1];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (rd0) ptr0 <= ptr0 + 6'd1;
        if (rd1) ptr1 <= ptr1 + 6'd1;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r0, input logic r1, input logic rdy);
        req0       = r0;
        req1       = r1;
        core_ready = rdy;
    endtask

    // Waits for the first write of a block, then checks all 16 words.
    task automatic check_block(input logic seq, input int glitch_at, output int sir_at);
        int          n;
        int          base;
        logic [31:0] exp_d;
        sir_at = 0;
        n = 0;
        while (!wr_en && n < 40) begin
            step();
            n++;
        end
        if (!wr_en) begin
            check_output("blk_start", 64'(wr_en), 64'd1);
            return;
        end
        base = seq ? 16 * nblk1 : 16 * nblk0;
        for (int i = 0; i < 16; i++) begin
            if (i == glitch_at) begin
                core_ready = 1'b0;
                if (seq) req1 = 1'b0;
                else     req0 = 1'b0;
            end
            exp_d = seq ? fifo1[base + i] : fifo0[base + i];
            check_output("blk_word",
                64'({wr_en, wr_addr, dout, set_input_ready, input_seq, (seq ? rd0 : rd1)}),
                64'({1'b1, 4'(i), exp_d, (i == 15), seq, 1'b0}));
            if (set_input_ready) sir_at = cyc;
            step();
        end
        check_output("blk_gap", 64'(wr_en), 64'd0);
        if (seq) nblk1++;
        else     nblk0++;
    endtask

    initial begin
        int s0, s1, s2, n, viol;
        logic [31:0] w;

        vecs[0].din  = 32'h6c6c6548;
        vecs[1].din  = 32'h6f77206f;
        vecs[2].din  = 32'h80646c72;
        for (int i = 3; i < 15; i++) begin
            w = 32'h0000_0000;
            w[7:0] = 8'(i * 17);
            vecs[i].din = w;
        end
        vecs[15].din = 32'h10010000;
        for (int i = 0; i < 16; i++) begin
            vecs[i].addr = 4'(i);
            vecs[i].last = (i == 15);
        end
        for (int i = 0; i < 64; i++) begin
            fifo0[i] = (i < 16) ? vecs[i].din : 32'hA000_0000 + 32'(i);
            fifo1[i] = 32'hB100_0000 + 32'(i);
        end

        tests = 0; failed = 0; nblk0 = 0; nblk1 = 0;
        cyc = 0; ptr0 = 6'd0; ptr1 = 6'd0;
        RST_N = 1'b0;
        blk_op0 = 8'h5A;
        blk_op1 = 8'hC3;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        #3;
        check_output("reset_state",
            64'({rd0, rd1, wr_en, wr_addr, dout, set_input_ready, blk_op, input_seq, idle}),
            64'({1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1}));
        step();
        step();

        // Single block, granted in the first cycle after reset release
        RST_N = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        step();
        check_output("first_grant_rd0", 64'({rd0, rd1, idle}), 64'({1'b1, 1'b0, 1'b0}));
        req0 = 1'b0;
        n = 0;
        while (!wr_en && n < 5) begin
            step();
            n++;
        end
        for (int i = 0; i < 16; i++) begin
            check_output("single_word",
                64'({wr_en, wr_addr, dout, set_input_ready, input_seq}),
                64'({1'b1, vecs[i].addr, vecs[i].din, vecs[i].last, 1'b0}));
            step();
        end
        nblk0 = 1;
        check_output("single_gap", 64'({wr_en, idle}), 64'({1'b0, 1'b0}));
        check_output("single_blk_op", 64'(blk_op), 64'h5A);
        step();
        check_output("single_idle", 64'(idle), 64'd1);

        // Backpressure: request held off while the core is not ready
        apply_stimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("bp_wait", 64'({rd1, idle, wr_en}), 64'({1'b0, 1'b1, 1'b0}));
        end
        core_ready = 1'b1;
        step();
        check_output("bp_rd1", 64'({rd1, wr_en}), 64'({1'b1, 1'b0}));
        req1 = 1'b0;
        step();
        check_output("bp_wr_en", 64'(wr_en), 64'd1);
        check_block(1'b1, -1, s0);
        check_output("bp_blk_op", 64'({blk_op, input_seq}), 64'({8'hC3, 1'b1}));
        step();

        // Contention and throughput
        blk_op0 = 8'h11;
        blk_op1 = 8'h22;
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_block(1'b0, -1, s0);
        check_output("cont_blk_op0", 64'(blk_op), 64'h11);
        check_block(1'b1, -1, s1);
        check_output("cont_blk_op1", 64'(blk_op), 64'h22);
        step();
        check_output("cont_idle", 64'(idle), 64'd1);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_block(1'b0, -1, s2);
        check_output("thru_gap_a", 64'(s1 - s0), 64'd19);
        check_output("thru_gap_b", 64'(s2 - s1), 64'd19);
        step();
        step();

        // Ready and request drop in the middle of a block
        blk_op0 = 8'h77;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_block(1'b0, 7, s0);
        step();
        step();
        check_output("glitch_after", 64'({idle, wr_en, rd0}), 64'({1'b1, 1'b0, 1'b0}));
        check_output("glitch_blk_op", 64'(blk_op), 64'h77);

        // Asynchronous reset in the middle of a block
        apply_stimulus(1'b1, 1'b0, 1'b1);
        n = 0;
        while (!(wr_en && wr_addr == 4'd5) && n < 40) begin
            step();
            n++;
        end
        check_output("rst_reach_w5", 64'({wr_en, wr_addr}), 64'({1'b1, 4'd5}));
        RST_N = 1'b0;
        #1;
        check_output("rst_mid_state",
            64'({rd0, rd1, wr_en, wr_addr, dout, set_input_ready, blk_op, input_seq, idle}),
            64'({1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1}));
        req0 = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        viol = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (wr_en || rd0 || rd1 || !idle) viol++;
        end
        check_output("rst_quiet", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
